// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder: FSM states,
// prefix bytes and the seven-segment hex font.
package kbd_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } kbd_state_e;

    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] BLANK  = 8'hFF;

    // Active-low segments, bit7..bit0 = a,b,c,d,e,f,g,dp
    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h03;
            4'h1:    seg = 8'h9F;
            4'h2:    seg = 8'h25;
            4'h3:    seg = 8'h0D;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h49;
            4'h6:    seg = 8'h41;
            4'h7:    seg = 8'h1F;
            4'h8:    seg = 8'h01;
            4'h9:    seg = 8'h09;
            4'hA:    seg = 8'h11;
            4'hB:    seg = 8'hC1;
            4'hC:    seg = 8'h63;
            4'hD:    seg = 8'h85;
            4'hE:    seg = 8'h61;
            4'hF:    seg = 8'h71;
            default: seg = BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/kbd_decoder_if.sv
// Pop interface between the keyboard receiver FIFO (master) and the decoder (slave).
interface kbd_decoder_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;

    modport master (
        output kb_data,
        output kb_ready,
        output kb_overflow,
        input  kb_nextdata_n
    );

    modport slave (
        input  kb_data,
        input  kb_ready,
        input  kb_overflow,
        output kb_nextdata_n
    );
endinterface

// File: rtl/kbd_ascii_rom.sv
// Scan code set 2 to lower-case ASCII lookup; unmapped codes give 00.
module kbd_ascii_rom (
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);

    // Pure lookup table
    always_comb begin
        case (scan_i)
            8'h1C: ascii_o = 8'h61;
            8'h32: ascii_o = 8'h62;
            8'h21: ascii_o = 8'h63;
            8'h23: ascii_o = 8'h64;
            8'h24: ascii_o = 8'h65;
            8'h2B: ascii_o = 8'h66;
            8'h34: ascii_o = 8'h67;
            8'h33: ascii_o = 8'h68;
            8'h43: ascii_o = 8'h69;
            8'h3B: ascii_o = 8'h6A;
            8'h42: ascii_o = 8'h6B;
            8'h4B: ascii_o = 8'h6C;
            8'h3A: ascii_o = 8'h6D;
            8'h31: ascii_o = 8'h6E;
            8'h44: ascii_o = 8'h6F;
            8'h4D: ascii_o = 8'h70;
            8'h15: ascii_o = 8'h71;
            8'h2D: ascii_o = 8'h72;
            8'h1B: ascii_o = 8'h73;
            8'h2C: ascii_o = 8'h74;
            8'h3C: ascii_o = 8'h75;
            8'h2A: ascii_o = 8'h76;
            8'h1D: ascii_o = 8'h77;
            8'h22: ascii_o = 8'h78;
            8'h35: ascii_o = 8'h79;
            8'h1A: ascii_o = 8'h7A;
            8'h45: ascii_o = 8'h30;
            8'h16: ascii_o = 8'h31;
            8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33;
            8'h25: ascii_o = 8'h34;
            8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;
            8'h3D: ascii_o = 8'h37;
            8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39;
            8'h29: ascii_o = 8'h20;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 make/break/extended decoder: pops scan bytes from the receiver FIFO,
// tracks the held key and press count, and drives eight hex digits.
module kbd_decoder
    import kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    kbd_decoder_if.slave     kb,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic [7:0]       o_seg0,
    output logic [7:0]       o_seg1,
    output logic [7:0]       o_seg2,
    output logic [7:0]       o_seg3,
    output logic [7:0]       o_seg4,
    output logic [7:0]       o_seg5,
    output logic [7:0]       o_seg6,
    output logic [7:0]       o_seg7
);

    kbd_state_e       state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic [7:0]       key_ascii_q, key_ascii_d;
    logic             key_held_q, key_held_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    logic       take_s;
    logic       make_s;
    logic       make_ext_s;
    logic       same_key_s;
    logic [7:0] rom_ascii_s;

    kbd_ascii_rom u_rom (
        .scan_i  (kb.kb_data),
        .ascii_o (rom_ascii_s)
    );

    // The head byte is consumed during the cycle the pop strobe is low
    assign take_s = ~nextdata_n_q & kb.kb_ready;

    // Next-state: pop strobe, sequence FSM and held-key bookkeeping
    always_comb begin
        state_d      = state_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_ascii_d  = key_ascii_q;
        key_held_d   = key_held_q;
        press_cnt_d  = press_cnt_q;
        make_s       = 1'b0;
        make_ext_s   = 1'b0;
        nextdata_n_d = ~(kb.kb_ready & nextdata_n_q);

        if (kb.kb_overflow) begin
            state_d    = S_IDLE;
            key_held_d = 1'b0;
        end else if (take_s) begin
            case (state_q)
                S_IDLE: begin
                    if (kb.kb_data == SC_BRK) begin
                        state_d = S_BRK;
                    end else if (kb.kb_data == SC_EXT) begin
                        state_d = S_EXT;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                S_EXT: begin
                    if (kb.kb_data == SC_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if (kb.kb_data == SC_EXT) begin
                        state_d = S_EXT;
                    end else begin
                        make_s     = 1'b1;
                        make_ext_s = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (key_held_q && (kb.kb_data == key_code_q) &&
                        ((state_q == S_EXT_BRK) == key_ext_q)) begin
                        key_held_d = 1'b0;
                    end else begin
                        key_held_d = key_held_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        // A make matching the held key is typematic repeat and changes nothing
        same_key_s = key_held_q && (kb.kb_data == key_code_q) && (make_ext_s == key_ext_q);
        if (make_s && !same_key_s) begin
            key_code_d  = kb.kb_data;
            key_ext_d   = make_ext_s;
            key_ascii_d = make_ext_s ? 8'h00 : rom_ascii_s;
            key_held_d  = 1'b1;
            press_cnt_d = press_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            press_cnt_d = press_cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nextdata_n_q <= 1'b1;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_ascii_q  <= 8'h00;
            key_held_q   <= 1'b0;
            press_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_ascii_q  <= key_ascii_d;
            key_held_q   <= key_held_d;
            press_cnt_q  <= press_cnt_d;
        end
    end

    assign kb.kb_nextdata_n = nextdata_n_q;
    assign key_code         = key_code_q;
    assign key_ext          = key_ext_q;
    assign key_ascii        = key_ascii_q;
    assign key_held         = key_held_q;
    assign press_cnt        = press_cnt_q;

    // Code and ASCII digits go dark when nothing is held
    assign o_seg0 = key_held_q ? hex_font(key_code_q[3:0])  : BLANK;
    assign o_seg1 = key_held_q ? hex_font(key_code_q[7:4])  : BLANK;
    assign o_seg2 = key_held_q ? hex_font(key_ascii_q[3:0]) : BLANK;
    assign o_seg3 = key_held_q ? hex_font(key_ascii_q[7:4]) : BLANK;
    assign o_seg4 = hex_font(press_cnt_q[3:0]);
    assign o_seg5 = hex_font(press_cnt_q[7:4]);
    assign o_seg6 = BLANK;
    assign o_seg7 = BLANK;

endmodule

// File: tb/tb_kbd_decoder.sv
// Self-checking bench for kbd_decoder: FIFO model plus a behavioural key model.
module tb_kbd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_code, key_ascii, press_cnt;
    logic       key_ext, key_held;
    logic [7:0] seg [8];

    kbd_decoder_if kb_if ();

    kbd_decoder #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .kb        (kb_if),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_ascii (key_ascii),
        .key_held  (key_held),
        .press_cnt (press_cnt),
        .o_seg0    (seg[0]),
        .o_seg1    (seg[1]),
        .o_seg2    (seg[2]),
        .o_seg3    (seg[3]),
        .o_seg4    (seg[4]),
        .o_seg5    (seg[5]),
        .o_seg6    (seg[6]),
        .o_seg7    (seg[7])
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo [$];
    int pulses = 0;
    int consec = 0;

    logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digits [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] font [16]   = '{8'h03,8'h9F,8'h25,8'h0D,8'h99,8'h49,8'h41,8'h1F,
                                8'h01,8'h09,8'h11,8'hC1,8'h63,8'h85,8'h61,8'h71};
    logic [7:0] pool [10]   = '{8'h1C,8'h32,8'h75,8'h29,8'h45,8'hF0,8'hE0,8'hF0,8'h6B,8'h1A};

    // Reference key state: what is held, how many presses, pending prefixes
    logic [7:0] m_code, m_ascii, m_cnt;
    logic       m_ext, m_held, m_pext, m_pbrk;

    function automatic logic [7:0] lut(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_ascii = 8'h00; m_cnt = 8'h00;
        m_ext = 1'b0; m_held = 1'b0; m_pext = 1'b0; m_pbrk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        if (m_pbrk) begin
            if (m_held && c == m_code && m_pext == m_ext) m_held = 1'b0;
            m_pbrk = 1'b0;
            m_pext = 1'b0;
        end else if (c == 8'hF0) begin
            m_pbrk = 1'b1;
        end else if (c == 8'hE0) begin
            m_pext = 1'b1;
        end else begin
            if (!(m_held && c == m_code && m_pext == m_ext)) begin
                m_code  = c;
                m_ext   = m_pext;
                m_ascii = m_pext ? 8'h00 : lut(c);
                m_held  = 1'b1;
                m_cnt   = m_cnt + 8'd1;
            end
            m_pext = 1'b0;
        end
    endtask

    task automatic model_ovf();
        m_pbrk = 1'b0; m_pext = 1'b0; m_held = 1'b0;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [7:0] e [8];
        e[0] = m_held ? font[m_code[3:0]]  : 8'hFF;
        e[1] = m_held ? font[m_code[7:4]]  : 8'hFF;
        e[2] = m_held ? font[m_ascii[3:0]] : 8'hFF;
        e[3] = m_held ? font[m_ascii[7:4]] : 8'hFF;
        e[4] = font[m_cnt[3:0]];
        e[5] = font[m_cnt[7:4]];
        e[6] = 8'hFF;
        e[7] = 8'hFF;
        check8({ctx, ".key_held"}, {7'd0, key_held}, {7'd0, m_held});
        check8({ctx, ".press_cnt"}, press_cnt, m_cnt);
        if (m_held) begin
            check8({ctx, ".key_code"}, key_code, m_code);
            check8({ctx, ".key_ext"}, {7'd0, key_ext}, {7'd0, m_ext});
            check8({ctx, ".key_ascii"}, key_ascii, m_ascii);
        end
        for (int i = 0; i < 8; i++) check8($sformatf("%s.seg%0d", ctx, i), seg[i], e[i]);
    endtask

    // Serve the queued bytes through the pop handshake; optionally overflow on each pop
    task automatic run_fifo(input bit ovf_on_pop);
        int   budget = 0;
        bit   low;
        bit   prev_low = 1'b0;
        logic [7:0] c;
        while (fifo.size() > 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
            low = !kb_if.kb_nextdata_n;
            if (low && prev_low) consec++;
            if (low) pulses++;
            prev_low = low;
            kb_if.kb_ready    = 1'b1;
            kb_if.kb_data     = fifo[0];
            kb_if.kb_overflow = ovf_on_pop && low;
            @(posedge clk);
            if (low) begin
                c = fifo.pop_front();
                if (ovf_on_pop) model_ovf();
                else model_byte(c);
            end
        end
        check8("fifo_budget", {7'd0, fifo.size() == 0}, 8'd1);
        fifo.delete();
        @(negedge clk);
        kb_if.kb_ready    = 1'b0;
        kb_if.kb_overflow = 1'b0;
        kb_if.kb_data     = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        kb_if.kb_data     = 8'h00;
        kb_if.kb_ready    = 1'b0;
        kb_if.kb_overflow = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check8("rst.nextdata_n", {7'd0, kb_if.kb_nextdata_n}, 8'd1);
        check_all("rst");
        check8("rst.key_code", key_code, 8'h00);
        check8("rst.seg4", seg[4], 8'h03);
        rst = 1'b0;

        // Basic make then release
        send(8'h1C);
        run_fifo(1'b0);
        check_all("make1C");
        check8("make1C.ascii_lit", key_ascii, 8'h61);
        check8("make1C.seg0_lit", seg[0], 8'h63);
        check8("make1C.seg3_lit", seg[3], 8'h41);
        send(8'hF0); send(8'h1C);
        run_fifo(1'b0);
        check_all("brk1C");
        check8("brk1C.seg4_lit", seg[4], 8'h9F);

        // Typematic
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        run_fifo(1'b0);
        check_all("typematic");
        check8("typematic.cnt_lit", press_cnt, 8'h01);

        // Extended key; plain break must not release it
        send(8'hE0); send(8'h75); send(8'hF0); send(8'h75);
        run_fifo(1'b0);
        check_all("ext_plain_brk");
        check8("ext.held_lit", {7'd0, key_held}, 8'd1);
        check8("ext.ascii_lit", key_ascii, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h75);
        run_fifo(1'b0);
        check_all("ext_brk");

        // Back-to-back pops
        pulses = 0; consec = 0;
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32);
        run_fifo(1'b0);
        check8("b2b.pulses", 8'(pulses), 8'd4);
        check8("b2b.consec_low", 8'(consec), 8'd0);
        check_all("b2b");

        // Counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
        run_fifo(1'b0);
        check_all("wrap");
        check8("wrap.cnt_lit", press_cnt, 8'h00);

        // Overflow after E0: next byte is a plain make
        send(8'hE0);
        run_fifo(1'b0);
        @(negedge clk);
        kb_if.kb_overflow = 1'b1;
        @(posedge clk);
        model_ovf();
        @(negedge clk);
        kb_if.kb_overflow = 1'b0;
        check_all("ovf_idle");
        send(8'h32);
        run_fifo(1'b0);
        check_all("ovf_then_32");
        check8("ovf.ext_lit", {7'd0, key_ext}, 8'd0);

        // Overflow coincident with a pop discards that byte
        send(8'h4B);
        run_fifo(1'b1);
        check_all("ovf_on_pop");

        // Randomised byte stream with occasional overflow
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                send(8'($urandom_range(0, 255)));
                run_fifo(1'b1);
            end else begin
                send((i % 7 == 3) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 9)]);
                run_fifo(1'b0);
            end
            check_all($sformatf("rand%0d", i));
        end

        // Async reset mid-cycle after F0, then the partial break is gone
        send(8'h1C);
        run_fifo(1'b0);
        send(8'hF0);
        run_fifo(1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check8("async_rst.nextdata_n", {7'd0, kb_if.kb_nextdata_n}, 8'd1);
        @(negedge clk);
        rst = 1'b0;
        send(8'h1C);
        run_fifo(1'b0);
        check_all("post_rst_make");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
